// File: rtl/til305_scroll_sequencer.sv
// Two-digit BCD counter with a vertical scroll sequencer for the TIL305 display.
// Single clock, prescaler-generated step enable; feeds the row-scan stage.
module til305_scroll_sequencer #(
    parameter int unsigned STEP_DIV     = 1500000,
    parameter int unsigned SCROLL_STEPS = 6,
    parameter int unsigned HOLD_STEPS   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       LOAD,
    input  logic [3:0] LOAD_TENS,
    input  logic [3:0] LOAD_UNITS,
    output logic [3:0] TENS,
    output logic [3:0] UNITS,
    output logic [2:0] SCR_TENS,
    output logic [2:0] SCR_UNITS,
    output logic [5:0] TENS_BASE,
    output logic [5:0] UNITS_BASE,
    output logic       STEP,
    output logic       WRAP
);

    localparam int unsigned PW = $clog2(STEP_DIV);
    localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_STEPS - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [2:0]    SCR_MAX   = 3'(SCROLL_STEPS - 1);
    localparam logic [5:0]    ROWS      = 6'(SCROLL_STEPS);

    typedef enum logic {
        ST_HOLD,
        ST_SCROLL
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    units_q, units_d;
    logic [2:0]    scr_t_q, scr_t_d;
    logic [2:0]    scr_u_q, scr_u_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;

    logic step_fire;
    logic hold_last;
    logic scr_last;
    logic units9;
    logic tens9;

    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    assign step_fire = EN && (presc_q == PRESC_MAX);
    assign hold_last = (hold_q == HOLD_MAX);
    assign scr_last  = (scr_u_q == SCR_MAX);
    assign units9    = (units_q == 4'd9);
    assign tens9     = (tens_q == 4'd9);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_HOLD;
            presc_q <= '0;
            hold_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            scr_t_q <= '0;
            scr_u_q <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            scr_t_q <= scr_t_d;
            scr_u_q <= scr_u_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (LOAD) begin
            state_d = ST_HOLD;
        end else if (step_fire) begin
            case (state_q)
                ST_HOLD:   if (hold_last) state_d = ST_SCROLL;
                ST_SCROLL: if (scr_last) state_d = ST_HOLD;
                default:   state_d = ST_HOLD;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q;
        hold_d  = hold_q;
        tens_d  = tens_q;
        units_d = units_q;
        scr_t_d = scr_t_q;
        scr_u_d = scr_u_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (LOAD) begin
            presc_d = '0;
            hold_d  = '0;
            tens_d  = clamp9(LOAD_TENS);
            units_d = clamp9(LOAD_UNITS);
            scr_t_d = '0;
            scr_u_d = '0;
        end else if (EN) begin
            presc_d = step_fire ? '0 : presc_q + PRESC_ONE;
            if (step_fire) begin
                step_d = 1'b1;
                case (state_q)
                    ST_HOLD: begin
                        if (hold_last) begin
                            hold_d  = '0;
                            scr_u_d = 3'd1;
                            scr_t_d = units9 ? 3'd1 : 3'd0;
                        end else begin
                            hold_d = hold_q + HOLD_ONE;
                        end
                    end
                    ST_SCROLL: begin
                        if (scr_last) begin
                            // commit: scroll finished, advance the count
                            scr_u_d = '0;
                            scr_t_d = '0;
                            if (units9) begin
                                units_d = '0;
                                if (tens9) begin
                                    tens_d = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    tens_d = tens_q + 4'd1;
                                end
                            end else begin
                                units_d = units_q + 4'd1;
                            end
                        end else begin
                            scr_u_d = scr_u_q + 3'd1;
                            if (units9) scr_t_d = scr_t_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign TENS       = tens_q;
    assign UNITS      = units_q;
    assign SCR_TENS   = scr_t_q;
    assign SCR_UNITS  = scr_u_q;
    assign STEP       = step_q;
    assign WRAP       = wrap_q;
    assign TENS_BASE  = {2'b00, tens_q} * ROWS + {3'b000, scr_t_q};
    assign UNITS_BASE = {2'b00, units_q} * ROWS + {3'b000, scr_u_q};

endmodule

// File: tb/tb_til305_scroll_sequencer.sv
// Scoreboard bench for til305_scroll_sequencer with a fast prescaler.
// Expected per-step snapshots come from a closed-form value/phase model.
module tb_til305_scroll_sequencer;

    localparam int DIV    = 4;
    localparam int SCR    = 6;
    localparam int HOLD   = 2;
    localparam int PERIOD = HOLD + SCR - 1;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] u;
        logic [2:0] st;
        logic [2:0] su;
        logic       wrap;
        logic [5:0] tb;
        logic [5:0] ub;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] LOAD_TENS = '0;
    logic [3:0] LOAD_UNITS = '0;
    logic [3:0] TENS, UNITS;
    logic [2:0] SCR_TENS, SCR_UNITS;
    logic [5:0] TENS_BASE, UNITS_BASE;
    logic       STEP, WRAP;

    int pass_cnt = 0;
    int total_cnt = 0;
    int stray_wrap = 0;
    exp_t sb[$];

    til305_scroll_sequencer #(
        .STEP_DIV(DIV),
        .SCROLL_STEPS(SCR),
        .HOLD_STEPS(HOLD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .EN(EN),
        .LOAD(LOAD),
        .LOAD_TENS(LOAD_TENS),
        .LOAD_UNITS(LOAD_UNITS),
        .TENS(TENS),
        .UNITS(UNITS),
        .SCR_TENS(SCR_TENS),
        .SCR_UNITS(SCR_UNITS),
        .TENS_BASE(TENS_BASE),
        .UNITS_BASE(UNITS_BASE),
        .STEP(STEP),
        .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // k = steps taken since the value was loaded (or reset)
    function automatic exp_t model(int start, int k);
        exp_t e;
        int v, ph;
        v = (start + k / PERIOD) % 100;
        ph = k % PERIOD;
        e.t = 4'(v / 10);
        e.u = 4'(v % 10);
        e.su = (ph >= HOLD) ? 3'(ph - HOLD + 1) : 3'd0;
        e.st = (v % 10 == 9) ? e.su : 3'd0;
        e.wrap = (k > 0) && (ph == 0) && (v == 0);
        e.tb = 6'((v / 10) * SCR + int'(e.st));
        e.ub = 6'((v % 10) * SCR + int'(e.su));
        return e;
    endfunction

    function automatic exp_t snap();
        return {TENS, UNITS, SCR_TENS, SCR_UNITS, WRAP, TENS_BASE, UNITS_BASE};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_expect(int start, int k0, int k1);
        for (int k = k0; k <= k1; k++) sb.push_back(model(start, k));
    endtask

    task automatic wait_step(output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 40) begin
            tick();
            cyc++;
            if (STEP === 1'b1) ok = 1'b1;
            else if (WRAP === 1'b1) stray_wrap++;
        end
    endtask

    task automatic do_load(logic [3:0] t, logic [3:0] u);
        LOAD_TENS = t;
        LOAD_UNITS = u;
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        bit ok;
        exp_t e, o;
        repeat (2) tick();
        total_cnt++;
        if ({snap(), STEP} !== '0) $display("FAIL reset_state got=%h want=0", {snap(), STEP});
        else pass_cnt++;
        RST = 1'b0;
        EN = 1'b1;
        repeat (26) tick();
        #2 RST = 1'b1;
        #1;
        total_cnt++;
        if ({snap(), STEP} !== '0) $display("FAIL async_reset got=%h want=0", {snap(), STEP});
        else pass_cnt++;
        tick();
        RST = 1'b0;
        push_expect(0, 1, 1);
        wait_step(cyc, ok);
        e = sb.pop_front();
        o = snap();
        total_cnt++;
        if (!ok || cyc != DIV) $display("FAIL first_step_latency got=%0d want=%0d", cyc, DIV);
        else pass_cnt++;
        total_cnt++;
        if (o !== e) $display("FAIL first_step_value got=%h want=%h", o, e);
        else pass_cnt++;
    endtask

    task automatic test_count();
        int cyc;
        bit ok;
        exp_t e, o;
        push_expect(0, 2, 8);
        for (int i = 2; i <= 8; i++) begin
            wait_step(cyc, ok);
            e = sb.pop_front();
            o = snap();
            total_cnt++;
            if (!ok || cyc != DIV) $display("FAIL count_interval step=%0d got=%0d want=%0d", i, cyc, DIV);
            else pass_cnt++;
            total_cnt++;
            if (o !== e) $display("FAIL count_value step=%0d got=%h want=%h", i, o, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_carry();
        int cyc;
        bit ok;
        exp_t e, o;
        do_load(4'd0, 4'd9);
        total_cnt++;
        if (snap() !== model(9, 0)) $display("FAIL carry_load got=%h want=%h", snap(), model(9, 0));
        else pass_cnt++;
        push_expect(9, 1, PERIOD);
        for (int i = 1; i <= PERIOD; i++) begin
            wait_step(cyc, ok);
            e = sb.pop_front();
            o = snap();
            total_cnt++;
            if (!ok || cyc != DIV) $display("FAIL carry_interval step=%0d got=%0d want=%0d", i, cyc, DIV);
            else pass_cnt++;
            total_cnt++;
            if (o !== e) $display("FAIL carry_value step=%0d got=%h want=%h", i, o, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        int cyc;
        bit ok;
        exp_t e, o;
        EN = 1'b0;
        stray_wrap = 0;
        do_load(4'hF, 4'hA);
        total_cnt++;
        if ({snap(), STEP} !== {model(99, 0), 1'b0})
            $display("FAIL wrap_clamp_load got=%h want=%h", snap(), model(99, 0));
        else pass_cnt++;
        EN = 1'b1;
        push_expect(99, 1, PERIOD);
        for (int i = 1; i <= PERIOD; i++) begin
            wait_step(cyc, ok);
            e = sb.pop_front();
            o = snap();
            total_cnt++;
            if (!ok || cyc != DIV) $display("FAIL wrap_interval step=%0d got=%0d want=%0d", i, cyc, DIV);
            else pass_cnt++;
            total_cnt++;
            if (o !== e) $display("FAIL wrap_value step=%0d got=%h want=%h", i, o, e);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (WRAP !== 1'b0) $display("FAIL wrap_width got=%b want=0", WRAP);
        else pass_cnt++;
        total_cnt++;
        if (stray_wrap != 0) $display("FAIL wrap_stray got=%0d want=0", stray_wrap);
        else pass_cnt++;
    endtask

    task automatic test_freeze();
        int cyc, bad, steps;
        bit ok;
        exp_t e, o;
        do_load(4'd2, 4'd5);
        push_expect(25, 1, 5);
        for (int i = 1; i <= 4; i++) begin
            wait_step(cyc, ok);
            e = sb.pop_front();
            o = snap();
            total_cnt++;
            if (!ok || o !== e) $display("FAIL freeze_pre step=%0d got=%h want=%h", i, o, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (SCR_UNITS !== 3'd3) $display("FAIL freeze_scr3 got=%0d want=3", SCR_UNITS);
        else pass_cnt++;
        repeat (2) tick();
        EN = 1'b0;
        e = model(25, 4);
        bad = 0;
        steps = 0;
        repeat (20) begin
            tick();
            if (snap() !== e) bad++;
            if (STEP !== 1'b0) steps++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL freeze_hold changed=%0d want=0", bad);
        else pass_cnt++;
        total_cnt++;
        if (steps != 0) $display("FAIL freeze_step got=%0d want=0", steps);
        else pass_cnt++;
        EN = 1'b1;
        wait_step(cyc, ok);
        e = sb.pop_front();
        o = snap();
        total_cnt++;
        if (!ok || cyc != DIV - 2) $display("FAIL freeze_resume got=%0d want=%0d", cyc, DIV - 2);
        else pass_cnt++;
        total_cnt++;
        if (o !== e) $display("FAIL freeze_value got=%h want=%h", o, e);
        else pass_cnt++;
    endtask

    task automatic test_coincident();
        int cyc;
        bit ok;
        exp_t e, o;
        do_load(4'd0, 4'd0);
        repeat (DIV - 1) tick();
        do_load(4'hC, 4'd3);
        total_cnt++;
        if ({snap(), STEP} !== {model(93, 0), 1'b0})
            $display("FAIL coincident_load got=%h want=%h", {snap(), STEP}, {model(93, 0), 1'b0});
        else pass_cnt++;
        push_expect(93, 1, 3);
        for (int i = 1; i <= 3; i++) begin
            wait_step(cyc, ok);
            e = sb.pop_front();
            o = snap();
            total_cnt++;
            if (!ok || cyc != DIV) $display("FAIL coincident_interval step=%0d got=%0d want=%0d", i, cyc, DIV);
            else pass_cnt++;
            total_cnt++;
            if (o !== e) $display("FAIL coincident_value step=%0d got=%h want=%h", i, o, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry();
        test_wrap();
        test_freeze();
        test_coincident();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
